preset_entry: RTL and testbench

Key-driven editor for a 4-digit countdown preset, the input-side counterpart to the stopwatch display path.
- Takes the debounced single-cycle key pulses, lets the user edit four BCD digits with the selected digit blinking, and converts the committed value to a 20-bit millisecond count in a multi-cycle sequence.
- Offers the result to the timer core through a valid/ack handshake.
- Digits and blanking masks feed the 7-segment control block while editing.

---
 rtl/preset_entry_if.sv | 25 ++
 rtl/preset_entry.sv | 137 +++++++++++++
 tb/tb_preset_entry.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/preset_entry_if.sv
// rtl/preset_entry_if.sv - key, display and preset handshake bundle for preset_entry
interface preset_entry_if;
    logic        key_sel;
    logic        key_inc;
    logic        key_ok;
    logic        preset_ack;
    logic [3:0]  digit0;
    logic [3:0]  digit1;
    logic [3:0]  digit2;
    logic [3:0]  digit3;
    logic [3:0]  blank;
    logic        edit_active;
    logic [19:0] preset_ms;
    logic        preset_valid;

    modport slave (
        input  key_sel, key_inc, key_ok, preset_ack,
        output digit0, digit1, digit2, digit3, blank, edit_active, preset_ms, preset_valid
    );

    modport master (
        output key_sel, key_inc, key_ok, preset_ack,
        input  digit0, digit1, digit2, digit3, blank, edit_active, preset_ms, preset_valid
    );
endinterface

// File: rtl/preset_entry.sv
// rtl/preset_entry.sv - 4-digit BCD countdown preset editor with blinking selection and ms conversion
module preset_entry #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int BLINK_MS = 250
) (
    input  logic           clk,
    input  logic           rst,
    preset_entry_if.slave  pe_if
);
    localparam int BLINK_CYC = CLK_HZ / 1000 * BLINK_MS - 1;
    localparam int CNT_W     = (BLINK_CYC >= 1) ? $clog2(BLINK_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_CYC);

    typedef enum logic [1:0] {S_IDLE, S_EDIT, S_CONV, S_OFFER} state_t;

    state_t             state_q, state_d;
    logic [3:0][3:0]    dig_q, dig_d;
    logic [1:0]         sel_q, sel_d;
    logic               phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [19:0]        acc_q, acc_d;
    logic [2:0]         step_q, step_d;
    logic [19:0]        ms_q, ms_d;
    logic               valid_q, valid_d;
    logic [3:0]         blank_q, blank_d;
    logic               edit_q, edit_d;
    logic               blink_restart;

    function automatic logic [19:0] times10(input logic [19:0] x);
        return (x << 3) + (x << 1);
    endfunction

    always_comb begin
        state_d       = state_q;
        dig_d         = dig_q;
        sel_d         = sel_q;
        acc_d         = acc_q;
        step_d        = step_q;
        ms_d          = ms_q;
        valid_d       = valid_q;
        phase_d       = phase_q;
        cnt_d         = cnt_q;
        blink_restart = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pe_if.key_sel) begin
                    state_d       = S_EDIT;
                    sel_d         = 2'd3;
                    blink_restart = 1'b1;
                end
            end
            S_EDIT: begin
                if (pe_if.key_ok) begin
                    state_d = S_CONV;
                    acc_d   = 20'd0;
                    step_d  = 3'd0;
                end else if (pe_if.key_sel) begin
                    sel_d         = sel_q - 2'd1;
                    blink_restart = 1'b1;
                end else if (pe_if.key_inc) begin
                    dig_d[sel_q]  = (dig_q[sel_q] == 4'd9) ? 4'd0 : dig_q[sel_q] + 4'd1;
                    blink_restart = 1'b1;
                end
            end
            S_CONV: begin
                // Most significant digit first: four accumulate steps, then a final x10 to ms
                if (step_q == 3'd4) begin
                    ms_d    = times10(acc_q);
                    valid_d = 1'b1;
                    state_d = S_OFFER;
                end else begin
                    acc_d  = times10(acc_q) + {16'd0, dig_q[2'd3 - step_q[1:0]]};
                    step_d = step_q + 3'd1;
                end
            end
            S_OFFER: begin
                if (pe_if.preset_ack) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Restarting the blink on every accepted edit keeps the selected digit visible
        if (blink_restart || state_d != S_EDIT) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        blank_d = (state_d == S_EDIT && phase_d) ? (4'b0001 << sel_d) : 4'b0000;
        edit_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dig_q   <= '0;
            sel_q   <= 2'd3;
            phase_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= 20'd0;
            step_q  <= 3'd0;
            ms_q    <= 20'd0;
            valid_q <= 1'b0;
            blank_q <= 4'b0000;
            edit_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dig_q   <= dig_d;
            sel_q   <= sel_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            ms_q    <= ms_d;
            valid_q <= valid_d;
            blank_q <= blank_d;
            edit_q  <= edit_d;
        end
    end

    assign pe_if.digit0       = dig_q[0];
    assign pe_if.digit1       = dig_q[1];
    assign pe_if.digit2       = dig_q[2];
    assign pe_if.digit3       = dig_q[3];
    assign pe_if.blank        = blank_q;
    assign pe_if.edit_active  = edit_q;
    assign pe_if.preset_ms    = ms_q;
    assign pe_if.preset_valid = valid_q;
endmodule

// File: tb/tb_preset_entry.sv
// tb/tb_preset_entry.sv - table-driven and sequence checks for preset_entry
module tb_preset_entry;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    preset_entry_if pe_if ();

    preset_entry #(.CLK_HZ(1000), .BLINK_MS(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .pe_if (pe_if)
    );

    wire [15:0] dig = {pe_if.digit3, pe_if.digit2, pe_if.digit1, pe_if.digit0};

    typedef struct {
        logic        s;
        logic        i;
        logic        o;
        logic        a;
        logic [15:0] dig;
        logic [3:0]  blank;
        logic        edit;
        logic        valid;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic s, input logic i, input logic o);
        pe_if.key_sel = s;
        pe_if.key_inc = i;
        pe_if.key_ok  = o;
        tick();
        pe_if.key_sel = 1'b0;
        pe_if.key_inc = 1'b0;
        pe_if.key_ok  = 1'b0;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!pe_if.preset_valid && edges < 20) begin
            tick();
            edges++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " digits"}, 32'(dig), 32'h0000);
        check({tag, " blank"}, 32'(pe_if.blank), 32'h0);
        check({tag, " edit_active"}, 32'(pe_if.edit_active), 32'd0);
        check({tag, " preset_ms"}, 32'(pe_if.preset_ms), 32'd0);
        check({tag, " preset_valid"}, 32'(pe_if.preset_valid), 32'd0);
    endtask

    initial begin
        int n;

        pe_if.key_sel    = 1'b0;
        pe_if.key_inc    = 1'b0;
        pe_if.key_ok     = 1'b0;
        pe_if.preset_ack = 1'b0;

        // Idle keys other than key_sel are ignored; then edit to 3200 with blink period 4
        vecs.push_back('{0, 1, 0, 0, 16'h0000, 4'h0, 0, 0});
        vecs.push_back('{0, 0, 1, 0, 16'h0000, 4'h0, 0, 0});
        vecs.push_back('{0, 1, 1, 0, 16'h0000, 4'h0, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 16'h0000, 4'h0, 0, 0});
        vecs.push_back('{0, 1, 1, 1, 16'h0000, 4'h0, 0, 0});
        vecs.push_back('{1, 0, 0, 0, 16'h0000, 4'h0, 1, 0});
        vecs.push_back('{0, 1, 0, 0, 16'h1000, 4'h0, 1, 0});
        vecs.push_back('{0, 1, 0, 0, 16'h2000, 4'h0, 1, 0});
        vecs.push_back('{0, 1, 0, 0, 16'h3000, 4'h0, 1, 0});
        vecs.push_back('{1, 0, 0, 0, 16'h3000, 4'h0, 1, 0});
        vecs.push_back('{0, 1, 0, 0, 16'h3100, 4'h0, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 16'h3100, 4'h0, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 16'h3100, 4'h0, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 16'h3100, 4'h0, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 16'h3100, 4'h4, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 16'h3100, 4'h4, 1, 0});
        vecs.push_back('{0, 1, 0, 0, 16'h3200, 4'h0, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 16'h3200, 4'h0, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 16'h3200, 4'h0, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 16'h3200, 4'h0, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 16'h3200, 4'h4, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 16'h3200, 4'h4, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 16'h3200, 4'h4, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 16'h3200, 4'h4, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 16'h3200, 4'h0, 1, 0});

        tick();
        tick();
        rst = 1'b0;
        check_reset_vals("reset");

        for (int k = 0; k < vecs.size(); k++) begin
            pe_if.key_sel    = vecs[k].s;
            pe_if.key_inc    = vecs[k].i;
            pe_if.key_ok     = vecs[k].o;
            pe_if.preset_ack = vecs[k].a;
            tick();
            pe_if.key_sel    = 1'b0;
            pe_if.key_inc    = 1'b0;
            pe_if.key_ok     = 1'b0;
            pe_if.preset_ack = 1'b0;
            check($sformatf("vec%0d digits", k), 32'(dig), 32'(vecs[k].dig));
            check($sformatf("vec%0d blank", k), 32'(pe_if.blank), 32'(vecs[k].blank));
            check($sformatf("vec%0d edit_active", k), 32'(pe_if.edit_active), 32'(vecs[k].edit));
            check($sformatf("vec%0d preset_valid", k), 32'(pe_if.preset_valid), 32'(vecs[k].valid));
        end

        // Commit 3200; keys held during CONV and OFFER must be ignored
        pulse(0, 0, 1);
        check("conv edit_active", 32'(pe_if.edit_active), 32'd1);
        check("conv blank", 32'(pe_if.blank), 32'h0);
        pe_if.key_sel = 1'b1;
        pe_if.key_inc = 1'b1;
        wait_valid(n);
        check("3200 valid latency", 32'(n), 32'd5);
        check("3200 preset_ms", 32'(pe_if.preset_ms), 32'd32000);
        check("3200 digits", 32'(dig), 32'h3200);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("offer hold%0d valid", k), 32'(pe_if.preset_valid), 32'd1);
            check($sformatf("offer hold%0d ms", k), 32'(pe_if.preset_ms), 32'd32000);
        end
        pe_if.key_sel    = 1'b0;
        pe_if.key_inc    = 1'b0;
        pe_if.preset_ack = 1'b1;
        tick();
        pe_if.preset_ack = 1'b0;
        check("ack valid drop", 32'(pe_if.preset_valid), 32'd0);
        check("ack edit_active", 32'(pe_if.edit_active), 32'd0);
        check("ack digits kept", 32'(dig), 32'h3200);

        // Wraps: digit3 3->0 via 9, four selects return to digit3, then build 9999
        pulse(1, 0, 0);
        for (int k = 0; k < 7; k++) pulse(0, 1, 0);
        check("digit wrap", 32'(dig), 32'h0200);
        for (int k = 0; k < 4; k++) pulse(1, 0, 0);
        for (int k = 0; k < 9; k++) pulse(0, 1, 0);
        check("sel wrap", 32'(dig), 32'h9200);
        pulse(1, 0, 0);
        for (int k = 0; k < 7; k++) pulse(0, 1, 0);
        pulse(1, 0, 0);
        for (int k = 0; k < 9; k++) pulse(0, 1, 0);
        pulse(1, 0, 0);
        for (int k = 0; k < 9; k++) pulse(0, 1, 0);
        check("9999 digits", 32'(dig), 32'h9999);

        // Simultaneous keys commit only; ack already high when OFFER is entered
        pulse(1, 1, 1);
        pe_if.preset_ack = 1'b1;
        check("simul digits", 32'(dig), 32'h9999);
        check("simul edit_active", 32'(pe_if.edit_active), 32'd1);
        wait_valid(n);
        check("9999 valid latency", 32'(n), 32'd5);
        check("9999 preset_ms", 32'(pe_if.preset_ms), 32'd99990);
        tick();
        pe_if.preset_ack = 1'b0;
        check("early ack one-cycle valid", 32'(pe_if.preset_valid), 32'd0);
        check("early ack idle", 32'(pe_if.edit_active), 32'd0);

        // Reset in CONV
        pulse(1, 0, 0);
        pulse(0, 0, 1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals("rst conv");

        // Reset in OFFER drops the pending preset
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        pulse(0, 0, 1);
        wait_valid(n);
        check("1000 valid latency", 32'(n), 32'd5);
        check("1000 preset_ms", 32'(pe_if.preset_ms), 32'd10000);
        tick();
        rst = 1'b1;
        pe_if.preset_ack = 1'b1;
        tick();
        rst = 1'b0;
        pe_if.preset_ack = 1'b0;
        check_reset_vals("rst offer");
        tick();
        check("post reset valid", 32'(pe_if.preset_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
